// File: rtl/aes_pkg.sv
// Shared AES-128 constants: S-box, round constants, key-schedule FSM states.
// INV_KS_FWD_PRE_EN adds the forward pre-expansion state.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef INV_KS_FWD_PRE_EN
    ST_FWD,
`endif
    ST_EMIT
  } ks_state_e;

  // Byte 0x00 sits in the top byte of the flattened table.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_FLAT[2047 - 8*int'(a) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  assign subbed = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: streams round keys NR..0 from the last round key.
// INV_KS_FWD_PRE_EN adds key_is_cipher and a forward pre-expansion from the cipher key.
//
// state   | meaning
// IDLE    | waiting for start
// FWD     | forward-expanding cipher key to round NR (macro builds only)
// EMIT    | presenting rk, stepping back one round per handshake
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef INV_KS_FWD_PRE_EN
  input  logic         key_is_cipher,
`endif
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  ks_state_e   state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_in, sub_out;
  logic [127:0] inv_key;

  assign {w0, w1, w2, w3} = rk;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

`ifdef INV_KS_FWD_PRE_EN
  logic [3:0]   fwd_cnt;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] fwd_key;

  // One S-box bank serves both directions; FWD rotates w3, EMIT rotates p3.
  assign sub_in = (state == ST_FWD) ? {w3[23:0], w3[31:24]} : {p3[23:0], p3[31:24]};
  assign f0 = w0 ^ sub_out ^ {rcon(4'(NR + 1) - fwd_cnt), 24'h0};
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
`else
  assign sub_in = {p3[23:0], p3[31:24]};
`endif

  aes_subword u_subword (
    .word   (sub_in),
    .subbed (sub_out)
  );

  assign p0 = w0 ^ sub_out ^ {rcon(rk_round), 24'h0};
  assign inv_key = {p0, p1, p2, p3};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rk       <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef INV_KS_FWD_PRE_EN
      fwd_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done) begin
            rk   <= key_in;
            busy <= 1'b1;
`ifdef INV_KS_FWD_PRE_EN
            if (key_is_cipher) begin
              state   <= ST_FWD;
              fwd_cnt <= 4'(NR);
            end else
`endif
            begin
              state    <= ST_EMIT;
              rk_round <= 4'(NR);
              rk_valid <= 1'b1;
            end
          end
        end
`ifdef INV_KS_FWD_PRE_EN
        ST_FWD: begin
          rk      <= fwd_key;
          fwd_cnt <= fwd_cnt - 4'd1;
          if (fwd_cnt == 4'd1) begin
            state    <= ST_EMIT;
            rk_round <= 4'(NR);
            rk_valid <= 1'b1;
          end
        end
`endif
        ST_EMIT: begin
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              state    <= ST_IDLE;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk       <= inv_key;
              rk_round <= rk_round - 4'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          rk_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
